// File: rtl/rand_pkg.sv
// Shared definitions for the shared random-byte source: state encoding,
// LFSR tap positions, data width and the LFSR next-state function.
package rand_pkg;

    localparam int RAND_W = 8;

    localparam int TAP_A = 4;
    localparam int TAP_B = 3;
    localparam int TAP_C = 2;
    localparam int TAP_D = 0;

    typedef enum logic {
        STEP  = 1'b0,
        READY = 1'b1
    } state_t;

    // The NOR term folds the all-zero state into the sequence (256 states, no lock-up)
    function automatic logic [RAND_W-1:0] lfsr_next(input logic [RAND_W-1:0] s);
        logic fb;
        fb = s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D] ^ (~|s[RAND_W-1:1]);
        return {fb, s[RAND_W-1:1]};
    endfunction

endpackage

// File: rtl/rand_lfsr8.sv
// 8-bit maximal-length LFSR with load and advance controls; load wins
// over advance, and the register resets to RESET_VAL.
module rand_lfsr8 import rand_pkg::*; #(
    parameter logic [RAND_W-1:0] RESET_VAL = 8'h01
) (
    input  logic              clk,
    input  logic              rs,
    input  logic [RAND_W-1:0] load_val,
    input  logic              load,
    input  logic              advance,
    output logic [RAND_W-1:0] value
);

    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            value <= RESET_VAL;
        end else if (load) begin
            value <= load_val;
        end else if (advance) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/rand_share_ctrl.sv
// Shares one LFSR among N_REQ requesters with round-robin grants, advancing
// the LFSR STEPS times between draws; supports run-time reseeding.
module rand_share_ctrl import rand_pkg::*; #(
    parameter int                N_REQ      = 4,
    parameter int                STEPS      = 8,
    parameter logic [RAND_W-1:0] RESET_SEED = 8'h01
) (
    input  logic              clk,
    input  logic              rs,
    input  logic [N_REQ-1:0]  req,
    input  logic              seed_load,
    input  logic [RAND_W-1:0] seed_data,
    output logic [N_REQ-1:0]  gnt,
    output logic [RAND_W-1:0] rand_out,
    output logic              ready
);

    localparam int CNT_W = $clog2(STEPS + 1);
    localparam int PTR_W = $clog2(N_REQ);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   step_cnt, cnt_nxt;
    logic [PTR_W-1:0]   rr_ptr, ptr_nxt, win_idx;
    logic               win_valid;
    logic               advance, grant;
    logic [N_REQ-1:0]   gnt_nxt;
    logic [RAND_W-1:0]  lfsr;

    rand_lfsr8 #(
        .RESET_VAL (RESET_SEED)
    ) u_lfsr (
        .clk      (clk),
        .rs       (rs),
        .load_val (seed_data),
        .load     (seed_load),
        .advance  (advance),
        .value    (lfsr)
    );

    // Scan from the far end toward rr_ptr so the last hit is the nearest one
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[(int'(rr_ptr) + k) % N_REQ]) begin
                win_valid = 1'b1;
                win_idx   = PTR_W'((int'(rr_ptr) + k) % N_REQ);
            end
        end
    end

    always_comb begin
        ptr_nxt = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
        gnt_nxt = '0;
        if (grant) begin
            gnt_nxt = N_REQ'(1) << win_idx;
        end
    end

    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            state    <= STEP;
            step_cnt <= '0;
        end else begin
            state    <= state_nxt;
            step_cnt <= cnt_nxt;
        end
    end

    // A seed load overrides both stepping and granting
    always_comb begin
        state_nxt = state;
        cnt_nxt   = step_cnt;
        advance   = 1'b0;
        grant     = 1'b0;
        if (seed_load) begin
            state_nxt = STEP;
            cnt_nxt   = '0;
        end else begin
            case (state)
                STEP: begin
                    advance = 1'b1;
                    cnt_nxt = step_cnt + CNT_W'(1);
                    if (step_cnt == CNT_W'(STEPS - 1)) begin
                        state_nxt = READY;
                    end
                end
                READY: begin
                    if (win_valid) begin
                        grant     = 1'b1;
                        state_nxt = STEP;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = STEP;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            gnt      <= '0;
            rand_out <= '0;
            rr_ptr   <= '0;
        end else begin
            gnt <= gnt_nxt;
            if (grant) begin
                rand_out <= lfsr;
                rr_ptr   <= ptr_nxt;
            end
        end
    end

    assign ready = (state == READY);

endmodule

// File: tb/tb_rand_share_ctrl.sv
// Randomized and directed bench for rand_share_ctrl against a
// transaction-level model of the shared random source.
module tb_rand_share_ctrl;

    localparam int N_REQ = 4;
    localparam int STEPS = 8;

    logic             clk = 1'b0;
    logic             rs;
    logic [N_REQ-1:0] req;
    logic             seed_load;
    logic [7:0]       seed_data;
    logic [N_REQ-1:0] gnt;
    logic [7:0]       rand_out;
    logic             ready;

    logic [1:0]       req_full;
    logic             seed_load_full;
    logic [7:0]       seed_data_full;
    logic [1:0]       gnt_full;
    logic [7:0]       rand_out_full;
    logic             ready_full;

    int               checks = 0;
    int               errors = 0;

    // Model: remaining advances before a draw may be served, plus the pointer
    logic [7:0]       m_lfsr;
    int               m_left;
    int               m_ptr;
    logic [N_REQ-1:0] m_gnt;
    logic [7:0]       m_rand;

    always #5 clk = ~clk;

    rand_share_ctrl #(
        .N_REQ      (N_REQ),
        .STEPS      (STEPS),
        .RESET_SEED (8'h01)
    ) dut (
        .clk       (clk),
        .rs        (rs),
        .req       (req),
        .seed_load (seed_load),
        .seed_data (seed_data),
        .gnt       (gnt),
        .rand_out  (rand_out),
        .ready     (ready)
    );

    rand_share_ctrl #(
        .N_REQ      (2),
        .STEPS      (1),
        .RESET_SEED (8'h01)
    ) dut_full (
        .clk       (clk),
        .rs        (rs),
        .req       (req_full),
        .seed_load (seed_load_full),
        .seed_data (seed_data_full),
        .gnt       (gnt_full),
        .rand_out  (rand_out_full),
        .ready     (ready_full)
    );

    function automatic logic [7:0] ref_next(input logic [7:0] s);
        logic fb;
        fb = s[4] ^ s[3] ^ s[2] ^ s[0] ^ (s[7:1] == 7'd0);
        return {fb, s[7:1]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_lfsr = 8'h01;
        m_left = STEPS;
        m_ptr  = 0;
        m_gnt  = '0;
        m_rand = 8'h00;
    endtask

    task automatic model_edge(input logic [N_REQ-1:0] r, input logic sl,
                              input logic [7:0] sd);
        m_gnt = '0;
        if (sl) begin
            m_lfsr = sd;
            m_left = STEPS;
        end else if (m_left > 0) begin
            m_lfsr = ref_next(m_lfsr);
            m_left--;
        end else if (r != '0) begin
            for (int k = 0; k < N_REQ; k++) begin
                int i;
                i = (m_ptr + k) % N_REQ;
                if (r[i]) begin
                    m_gnt[i] = 1'b1;
                    m_rand   = m_lfsr;
                    m_ptr    = (i + 1) % N_REQ;
                    m_left   = STEPS;
                    break;
                end
            end
        end
    endtask

    // Drive at the falling edge, advance the model on the rising edge,
    // compare at the next falling edge
    task automatic applyStimulus(input logic [N_REQ-1:0] r, input logic sl,
                                 input logic [7:0] sd);
        req       = r;
        seed_load = sl;
        seed_data = sd;
        @(posedge clk);
        model_edge(r, sl, sd);
        @(negedge clk);
        checkOutput("gnt", 32'(gnt), 32'(m_gnt));
        checkOutput("rand_out", 32'(rand_out), 32'(m_rand));
        checkOutput("ready", 32'(ready), 32'(m_left == 0));
    endtask

    // Asserted between edges so the clear must be asynchronous
    task automatic applyReset(input string tag);
        #2 rs = 1'b1;
        #1;
        checkOutput({tag, "_gnt"}, 32'(gnt), 32'd0);
        checkOutput({tag, "_rand"}, 32'(rand_out), 32'd0);
        checkOutput({tag, "_ready"}, 32'(ready), 32'd0);
        model_reset();
        @(negedge clk);
        req       = '0;
        seed_load = 1'b0;
        rs        = 1'b0;
    endtask

    task automatic runBaseline(input string tag);
        for (int c = 0; c < STEPS + 1; c++) applyStimulus(4'b0001, 1'b0, 8'h00);
        checkOutput({tag, "_first_gnt"}, 32'(gnt), 32'h1);
        checkOutput({tag, "_first_rand"}, 32'(rand_out), 32'hE2);
        for (int c = 0; c < STEPS + 1; c++) applyStimulus(4'b0001, 1'b0, 8'h00);
        checkOutput({tag, "_second_gnt"}, 32'(gnt), 32'h1);
        checkOutput({tag, "_second_rand"}, 32'(rand_out), 32'h48);
    endtask

    initial begin
        logic [N_REQ-1:0] order[$];
        int               when[$];
        logic [7:0]       expect_val;
        int               seen[256];
        int               grants;
        int               distinct;
        int               budget;

        rs             = 1'b1;
        req            = '0;
        seed_load      = 1'b0;
        seed_data      = 8'h00;
        req_full       = '0;
        seed_load_full = 1'b0;
        seed_data_full = 8'h00;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_gnt", 32'(gnt), 32'd0);
        checkOutput("reset_rand", 32'(rand_out), 32'd0);
        checkOutput("reset_ready", 32'(ready), 32'd0);
        rs = 1'b0;

        $display("[TB] single requester after reset");
        runBaseline("base");

        $display("[TB] all requesters held");
        applyReset("rst_rr");
        for (int c = 1; c <= 5 * (STEPS + 1); c++) begin
            applyStimulus(4'b1111, 1'b0, 8'h00);
            if (gnt != '0) begin
                order.push_back(gnt);
                when.push_back(c);
            end
        end
        checkOutput("rr_count", 32'(order.size()), 32'd5);
        if (order.size() == 5) begin
            checkOutput("rr_order0", 32'(order[0]), 32'h1);
            checkOutput("rr_order1", 32'(order[1]), 32'h2);
            checkOutput("rr_order2", 32'(order[2]), 32'h4);
            checkOutput("rr_order3", 32'(order[3]), 32'h8);
            checkOutput("rr_order4", 32'(order[4]), 32'h1);
            for (int i = 1; i < 5; i++)
                checkOutput("rr_spacing", 32'(when[i] - when[i-1]), 32'(STEPS + 1));
        end

        $display("[TB] zero seed mid-step");
        applyReset("rst_seed");
        for (int c = 0; c < 3; c++) applyStimulus(4'b0001, 1'b0, 8'h00);
        applyStimulus(4'b0001, 1'b1, 8'h00);
        for (int c = 0; c < STEPS + 1; c++) applyStimulus(4'b0001, 1'b0, 8'h00);
        checkOutput("seed0_gnt", 32'(gnt), 32'h1);
        checkOutput("seed0_rand", 32'(rand_out), 32'h71);

        $display("[TB] seed and request together in ready");
        applyReset("rst_ready");
        for (int c = 0; c < STEPS; c++) applyStimulus(4'b0000, 1'b0, 8'h00);
        checkOutput("ready_before_seed", 32'(ready), 32'd1);
        applyStimulus(4'b0100, 1'b1, 8'h5A);
        checkOutput("seed_blocks_gnt", 32'(gnt), 32'd0);
        expect_val = 8'h5A;
        for (int c = 0; c < STEPS; c++) expect_val = ref_next(expect_val);
        for (int c = 0; c < STEPS + 1; c++) applyStimulus(4'b0100, 1'b0, 8'h00);
        checkOutput("post_seed_gnt", 32'(gnt), 32'h4);
        checkOutput("post_seed_rand", 32'(rand_out), 32'(expect_val));

        $display("[TB] reset during step and on a grant");
        applyReset("rst_pre");
        for (int c = 0; c < STEPS + 4; c++) applyStimulus(4'b0001, 1'b0, 8'h00);
        applyReset("rst_midstep");
        runBaseline("after_midstep");
        budget = 0;
        while (m_gnt == '0 && budget < 3 * (STEPS + 1)) begin
            applyStimulus(4'b0001, 1'b0, 8'h00);
            budget++;
        end
        checkOutput("gnt_seen_before_rst", 32'(gnt), 32'h1);
        applyReset("rst_on_gnt");
        runBaseline("after_gnt_rst");

        $display("[TB] randomized traffic");
        applyReset("rst_rand");
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                applyReset("rst_random");
            end else begin
                applyStimulus(4'($urandom_range(0, 15)),
                              ($urandom_range(0, 15) == 0),
                              8'($urandom_range(0, 255)));
            end
        end

        $display("[TB] full period with one step per draw");
        applyReset("rst_full");
        foreach (seen[i]) seen[i] = 0;
        grants   = 0;
        budget   = 0;
        req_full = 2'b01;
        while (grants < 256 && budget < 700) begin
            @(negedge clk);
            budget++;
            if (gnt_full[0]) begin
                seen[rand_out_full]++;
                grants++;
            end
        end
        req_full = 2'b00;
        checkOutput("full_grants", 32'(grants), 32'd256);
        distinct = 0;
        foreach (seen[i]) if (seen[i] == 1) distinct++;
        checkOutput("full_distinct", 32'(distinct), 32'd256);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rand_share_ctrl.md
Name: rand_share_ctrl

Overview:
- Owns one 8-bit maximal-length LFSR (256-state sequence, all-zero state included) and shares it among N_REQ requesters using round-robin arbitration.
- After every grant, the LFSR advances STEPS times before it serves the next draw, so successive consumers never receive adjacent sequence values.
- Supports run-time reseeding.
- Sits between the game and test logic that needs random bytes and the single random source.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- STEPS, 8, LFSR advances between draws (>=1).
- RESET_SEED, 8'h01, LFSR value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rs  input  1  reset, asynchronous, active-high.
- req  input  N_REQ  per-requester draw request; level, held until granted.
- seed_load  input  1  load seed_data into the LFSR (one-cycle pulse).
- seed_data  input  8  seed value.
- gnt  output  N_REQ  one-hot grant, one-cycle pulse, registered.
- rand_out  output  8  value delivered with gnt; holds until the next grant.
- ready  output  1  high while state==READY.

Behaviour:
- LFSR next-state: lfsr <= {lfsr[4]^lfsr[3]^lfsr[2]^lfsr[0]^(~|lfsr[7:1]), lfsr[7:1]}.
  - 0x01 -> 0x00 -> 0x80; no lock-up state.
  - The LFSR advances only in the STEP state.
- Reset (async, rs=1): lfsr=RESET_SEED, state=STEP, step_cnt=0, rr_ptr=0, gnt=0, rand_out=0, ready=0.
- States: STEP, READY.
- STEP:
  - Each cycle the LFSR advances and step_cnt increments.
  - When step_cnt==STEPS-1 (on that cycle's advance), the next state is READY.
  - req is ignored.
- READY:
  - LFSR holds.
  - If req!=0, the winner is the first set bit at or after rr_ptr (wrapping).
  - At that edge: gnt<=onehot(winner), rand_out<=lfsr, rr_ptr<=(winner+1) mod N_REQ, step_cnt<=0, state<=STEP.
  - If req==0, stay in READY.
- gnt is high for exactly one cycle. A requester that keeps req high after gnt is served again at its next round-robin turn.
- Latency:
  - A request sampled in READY is granted on the next cycle.
  - Minimum grant spacing is STEPS+1 cycles.
  - The first grant after reset can occur no earlier than STEPS+1 cycles after rs deasserts.
- seed_load has priority over everything except rs, in any state:
  - lfsr<=seed_data, state<=STEP, step_cnt<=0.
  - No gnt that cycle; rr_ptr unchanged; rand_out unchanged.
- seed_load together with req in READY: the seed wins, no grant, and the request stays pending.
- rs asserted mid-STEP or on a grant cycle: all state returns to reset values immediately. A gnt pulse in flight is cleared.
- step_cnt width is $clog2(STEPS+1). No overflow is possible because it is cleared on entry to STEP.

Decomposition:
- Shared package/header rand_pkg:
  - State encoding (STEP=1'b0, READY=1'b1).
  - LFSR tap constants (4,3,2,0).
  - Width constant RAND_W=8.
- Sub-module rand_lfsr8:
  - Inputs: clk, rs, init value, load, advance. Output: 8-bit state.
  - Implements the next-state equation above.
- rand_share_ctrl contains the FSM, step counter, round-robin arbiter and output registers.

Test Plan:
- Reset, STEPS=8, req=4'b0001 held:
  - Sequence 0x01->00->80->40->20->10->88->C4->E2.
  - Expect gnt=4'b0001, rand_out=0xE2 on the 10th cycle after rs deasserts.
  - Next grant rand_out=0x48, 9 cycles later.
- req=4'b1111 held:
  - Expect gnt order 0001, 0010, 0100, 1000, 0001, spaced 9 cycles apart.
  - Expect rand_out 0xE2, 0x48, ... per the LFSR sequence.
- seed_load=1 with seed_data=0x00 mid-STEP:
  - The step count restarts.
  - 8 cycles later the state is 0x71; the next grant delivers 0x71.
- In READY, seed_load and req=4'b0100 in the same cycle:
  - No gnt that cycle.
  - Grant to bit 2 arrives STEPS+1 cycles later with the post-seed value.
- rs pulsed during STEP and on the gnt cycle:
  - gnt, rand_out and ready clear immediately (asynchronously).
  - The post-reset sequence repeats the first scenario exactly.
- Full-period check: STEPS=1, one requester held:
  - 256 consecutive grants produce every value 0x00..0xFF exactly once.
